// File: rtl/stack_ctrl_if.sv
// Datapath-facing handshake bundle of the stack controller: push/pop handshakes,
// flush request and status/error flags.
interface stack_ctrl_if #(
  parameter int n = 8
);
  logic         push_valid;
  logic [n-1:0] push_data;
  logic         push_ready;
  logic         pop_valid_in;
  logic         pop_ready;
  logic         pop_valid;
  logic [n-1:0] pop_data;
  logic         clr;
  logic         empty;
  logic         full;
  logic         ovf;
  logic         unf;

  modport master (
    output push_valid, push_data, pop_valid_in, clr,
    input  push_ready, pop_ready, pop_valid, pop_data, empty, full, ovf, unf
  );

  modport slave (
    input  push_valid, push_data, pop_valid_in, clr,
    output push_ready, pop_ready, pop_valid, pop_data, empty, full, ovf, unf
  );
endinterface

// File: rtl/stack_ctrl.sv
// Stack controller: commands an external empty-ascending SP register, owns the
// storage array and offers push/pop handshakes with sticky overflow/underflow flags.
module stack_ctrl #(
  parameter int n     = 8,
  parameter int aw    = 8,
  parameter int depth = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [aw-1:0] sp,
  output logic [1:0]    sp_ctrl,
  stack_ctrl_if.slave   bus
);

  localparam int            iw       = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [aw-1:0] depth_sp = aw'(depth);

  localparam logic [1:0] SP_HOLD = 2'b00;
  localparam logic [1:0] SP_CLR  = 2'b01;
  localparam logic [1:0] SP_INC  = 2'b10;
  localparam logic [1:0] SP_DEC  = 2'b11;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    POP_RD = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [n-1:0]   mem_q [depth];
  logic [n-1:0]   pop_data_q, pop_data_d;
  logic           pop_valid_q, pop_valid_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           mem_we;
  logic [iw-1:0]  mem_idx;
  logic           sp_empty;
  logic           sp_full;

  // sp addresses the next free slot on a push, and the top word once decremented in POP_RD.
  assign mem_idx  = sp[iw-1:0];
  assign sp_empty = (sp == '0);
  assign sp_full  = (sp == depth_sp);

  assign bus.pop_valid = pop_valid_q;
  assign bus.pop_data  = pop_data_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;

  always_comb begin
    state_d        = state_q;
    sp_ctrl        = SP_HOLD;
    bus.push_ready = 1'b0;
    bus.pop_ready  = 1'b0;
    bus.empty      = sp_empty;
    bus.full       = sp_full;
    pop_valid_d    = 1'b0;
    pop_data_d     = pop_data_q;
    ovf_d          = ovf_q;
    unf_d          = unf_q;
    mem_we         = 1'b0;

    unique case (state_q)
      INIT: begin
        sp_ctrl   = SP_CLR;
        bus.empty = 1'b1;
        bus.full  = 1'b0;
        state_d   = IDLE;
      end

      IDLE: begin
        if (bus.clr) begin
          sp_ctrl = SP_CLR;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end else begin
          bus.pop_ready  = !sp_empty;
          bus.push_ready = !bus.pop_valid_in && !sp_full;
          if (bus.pop_valid_in && !sp_empty) begin
            sp_ctrl = SP_DEC;
            state_d = POP_RD;
          end else if (bus.push_valid && bus.push_ready) begin
            sp_ctrl = SP_INC;
            mem_we  = 1'b1;
          end
          // A rejected push only counts as overflow when no pop competed for the cycle.
          if (bus.push_valid && sp_full && !bus.pop_valid_in) begin
            ovf_d = 1'b1;
          end
          if (bus.pop_valid_in && sp_empty) begin
            unf_d = 1'b1;
          end
        end
      end

      POP_RD: begin
        pop_data_d  = mem_q[mem_idx];
        pop_valid_d = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d = INIT;
      end
    endcase

    // Keep the SP register clearing on every edge while reset is held.
    if (!rst_n) begin
      sp_ctrl = SP_CLR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= bus.push_data;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: a queue-based stack model checked every cycle, plus a
// directed sequence with hand-computed literal expectations, then random traffic.
module tb_stack_ctrl;

  localparam int N     = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] sp_reg = '0;
  logic [1:0]    sp_ctrl;

  int n_checks = 0;
  int n_pass   = 0;

  stack_ctrl_if #(.n(N)) bus ();

  stack_ctrl #(.n(N), .aw(AW), .depth(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sp      (sp_reg),
    .sp_ctrl (sp_ctrl),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the external SP register that the controller commands.
  always @(posedge clk) begin
    case (sp_ctrl)
      2'b01:   sp_reg <= '0;
      2'b10:   sp_reg <= sp_reg + 1'b1;
      2'b11:   sp_reg <= sp_reg - 1'b1;
      default: sp_reg <= sp_reg;
    endcase
  end

  // Behavioural model: the stack is a queue; a pop is accepted, then the block
  // is busy one cycle, then the strobe appears with the popped word.
  bit [N-1:0] m_stack[$];
  bit         m_ovf     = 1'b0;
  bit         m_unf     = 1'b0;
  bit         m_init    = 1'b1;
  bit         m_busy    = 1'b0;
  bit         m_pv      = 1'b0;
  bit [N-1:0] m_pd      = '0;
  bit [N-1:0] m_pending = '0;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_stack.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_pv   = 1'b0;
      m_pd   = '0;
      m_init = 1'b1;
      m_busy = 1'b0;
    end else begin
      m_pv = 1'b0;
      if (m_init) begin
        m_init = 1'b0;
      end else if (m_busy) begin
        m_busy = 1'b0;
        m_pv   = 1'b1;
        m_pd   = m_pending;
      end else if (bus.clr) begin
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else if (bus.pop_valid_in) begin
        if (m_stack.size() == 0) begin
          m_unf = 1'b1;
        end else begin
          m_pending = m_stack.pop_back();
          m_busy    = 1'b1;
        end
      end else if (bus.push_valid) begin
        if (m_stack.size() == DEPTH) m_ovf = 1'b1;
        else m_stack.push_back(bus.push_data);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic compareModel();
    int       cnt;
    bit       e, f, xpr, xpo;
    bit [1:0] xs;
    cnt = m_stack.size();
    e   = (cnt == 0);
    f   = (cnt == DEPTH);
    if (!rst_n) begin
      checkOutput("rst_sp_ctrl", sp_ctrl, 2'b01);
      checkOutput("rst_pop_valid", bus.pop_valid, 0);
      checkOutput("rst_pop_data", bus.pop_data, 0);
      checkOutput("rst_ovf", bus.ovf, 0);
      checkOutput("rst_unf", bus.unf, 0);
      checkOutput("rst_push_ready", bus.push_ready, 0);
      checkOutput("rst_pop_ready", bus.pop_ready, 0);
      checkOutput("rst_empty", bus.empty, 1);
      checkOutput("rst_full", bus.full, 0);
      return;
    end
    checkOutput("m_sp", sp_reg, cnt);
    checkOutput("m_pop_valid", bus.pop_valid, m_pv);
    checkOutput("m_pop_data", bus.pop_data, m_pd);
    checkOutput("m_ovf", bus.ovf, m_ovf);
    checkOutput("m_unf", bus.unf, m_unf);
    if (m_init) begin
      checkOutput("m_init_sp_ctrl", sp_ctrl, 2'b01);
      checkOutput("m_init_push_ready", bus.push_ready, 0);
      checkOutput("m_init_pop_ready", bus.pop_ready, 0);
      checkOutput("m_init_empty", bus.empty, 1);
      checkOutput("m_init_full", bus.full, 0);
    end else if (m_busy) begin
      checkOutput("m_busy_sp_ctrl", sp_ctrl, 2'b00);
      checkOutput("m_busy_push_ready", bus.push_ready, 0);
      checkOutput("m_busy_pop_ready", bus.pop_ready, 0);
    end else begin
      if (bus.clr) begin
        xs  = 2'b01;
        xpr = 1'b0;
        xpo = 1'b0;
      end else begin
        xpo = !e;
        xpr = !bus.pop_valid_in && !f;
        if (bus.pop_valid_in && !e)      xs = 2'b11;
        else if (bus.push_valid && xpr) xs = 2'b10;
        else                            xs = 2'b00;
      end
      checkOutput("m_sp_ctrl", sp_ctrl, xs);
      checkOutput("m_push_ready", bus.push_ready, xpr);
      checkOutput("m_pop_ready", bus.pop_ready, xpo);
      checkOutput("m_empty", bus.empty, e);
      checkOutput("m_full", bus.full, f);
    end
  endtask

  initial forever begin
    @(negedge clk);
    compareModel();
  end

  task automatic applyStimulus(input bit pv, input bit [N-1:0] pd, input bit ppv, input bit c);
    bus.push_valid   = pv;
    bus.push_data    = pd;
    bus.pop_valid_in = ppv;
    bus.clr          = c;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doPush(input bit [N-1:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("push_sp_ctrl", sp_ctrl, 2'b10);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic doPop(input bit [N-1:0] exp_data);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("pop_accept_sp_ctrl", sp_ctrl, 2'b11);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("pop_strobe_early", bus.pop_valid, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("pop_strobe", bus.pop_valid, 1);
    checkOutput("pop_data", bus.pop_data, exp_data);
    nextCycle();
  endtask

  initial begin
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // INIT cycle, then idle with an empty stack
    @(negedge clk);
    checkOutput("init_sp_ctrl", sp_ctrl, 2'b01);
    checkOutput("init_push_ready", bus.push_ready, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("idle_sp", sp_reg, 0);
    checkOutput("idle_empty", bus.empty, 1);
    checkOutput("idle_full", bus.full, 0);
    checkOutput("idle_push_ready", bus.push_ready, 1);
    checkOutput("idle_pop_ready", bus.pop_ready, 0);
    nextCycle();

    doPush(8'h11);
    doPush(8'h22);
    doPush(8'h33);
    @(negedge clk);
    checkOutput("after_push_sp", sp_reg, 3);
    checkOutput("after_push_empty", bus.empty, 0);
    nextCycle();

    doPop(8'h33);
    doPop(8'h22);
    @(negedge clk);
    checkOutput("after_pop_sp", sp_reg, 1);
    nextCycle();

    // Fill to capacity, then push into a full stack
    for (int i = 0; i < 15; i++) doPush(8'hB0 + 8'(i));
    @(negedge clk);
    checkOutput("fill_sp", sp_reg, 16);
    checkOutput("fill_full", bus.full, 1);
    nextCycle();
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("full_push_ready", bus.push_ready, 0);
    checkOutput("full_sp_ctrl", sp_ctrl, 2'b00);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("full_ovf", bus.ovf, 1);
    checkOutput("full_sp_kept", sp_reg, 16);
    checkOutput("full_still", bus.full, 1);
    nextCycle();
    doPop(8'hBE);
    @(negedge clk);
    checkOutput("full_dropped", bus.full, 0);
    nextCycle();

    // Drain to empty, then pop on empty
    for (int i = 13; i >= 0; i--) doPop(8'hB0 + 8'(i));
    doPop(8'h11);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("empty_pop_ready", bus.pop_ready, 0);
    checkOutput("empty_pop_sp_ctrl", sp_ctrl, 2'b00);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("empty_unf", bus.unf, 1);
    checkOutput("empty_sp_kept", sp_reg, 0);
    checkOutput("empty_ovf_sticky", bus.ovf, 1);
    nextCycle();

    // Simultaneous push and pop on a non-empty stack: pop wins, push follows
    doPush(8'h44);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("both_push_ready", bus.push_ready, 0);
    checkOutput("both_pop_ready", bus.pop_ready, 1);
    checkOutput("both_sp_ctrl", sp_ctrl, 2'b11);
    nextCycle();
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("both_busy_push_ready", bus.push_ready, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("both_pop_valid", bus.pop_valid, 1);
    checkOutput("both_pop_data", bus.pop_data, 8'h44);
    checkOutput("both_push_now_ready", bus.push_ready, 1);
    checkOutput("both_push_sp_ctrl", sp_ctrl, 2'b10);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("both_sp", sp_reg, 1);
    nextCycle();

    for (int i = 0; i < 4; i++) doPush(8'h60 + 8'(i));
    @(negedge clk);
    checkOutput("pre_clr_sp", sp_reg, 5);
    checkOutput("pre_clr_ovf", bus.ovf, 1);
    checkOutput("pre_clr_unf", bus.unf, 1);
    nextCycle();

    // Flush with pending requests that must be ignored
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("clr_sp_ctrl", sp_ctrl, 2'b01);
    checkOutput("clr_push_ready", bus.push_ready, 0);
    checkOutput("clr_pop_ready", bus.pop_ready, 0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("clr_sp", sp_reg, 0);
    checkOutput("clr_ovf", bus.ovf, 0);
    checkOutput("clr_unf", bus.unf, 0);
    checkOutput("clr_empty", bus.empty, 1);
    nextCycle();

    // Reset while a pop is in flight
    doPush(8'h66);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    nextCycle();
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("midpop_rst_pop_valid", bus.pop_valid, 0);
    checkOutput("midpop_rst_sp_ctrl", sp_ctrl, 2'b01);
    nextCycle();
    @(negedge clk);
    checkOutput("midpop_rst_pop_valid2", bus.pop_valid, 0);
    nextCycle();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midpop_init_sp_ctrl", sp_ctrl, 2'b01);
    checkOutput("midpop_init_pop_valid", bus.pop_valid, 0);
    checkOutput("midpop_init_push_ready", bus.push_ready, 0);
    nextCycle();

    // Random traffic, biased toward pushes so the full boundary is reached
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) < 55, N'($urandom), $urandom_range(0, 99) < 35,
                    $urandom_range(0, 99) < 2);
      rst_n = ($urandom_range(0, 399) != 0);
      nextCycle();
    end
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    repeat (3) nextCycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
